memory_system: RTL and testbench

MEMORY_SYSTEM -- requirements
Module: memory_system

---
 rtl/memory_system.sv | 197 +++++++++++++++++++
 tb/tb_memory_system.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_system.sv
// memory_system: unified instruction/data main memory with an independent
// fetch port and data port, plus a hardware stack with sticky overflow and
// underflow flags. After reset the stack RAM can be swept to zero while
// busy is high. Main memory keeps its contents across reset.
//
// Handshake: every request input is a level sampled at a rising clock edge
// while the block is ready (busy=0); a request has no effect while busy=1.
// A sampled fetch or load is answered by a one-cycle valid pulse after that
// edge, with its data held on the output until the next answered request.
// There is no back-pressure and no stall.
module memory_system #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 16,
    parameter int STACK_DEPTH_LOG2 = 8,
    parameter bit CLEAR_ON_RESET   = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    // fetch port
    input  logic [ADDR_WIDTH-1:0]       program_counter,
    input  logic                        fetch_enable,
    output logic [DATA_WIDTH-1:0]       current_instruction,
    output logic                        instruction_valid,
    // data port
    input  logic [ADDR_WIDTH-1:0]       address,
    input  logic [DATA_WIDTH-1:0]       value,
    input  logic                        memory_store_enable,
    input  logic                        memory_load_enable,
    output logic [DATA_WIDTH-1:0]       at_memory,
    output logic                        memory_valid,
    // stack port and status
    input  logic                        stack_push,
    input  logic                        stack_pop,
    output logic [DATA_WIDTH-1:0]       stack_top,
    output logic [STACK_DEPTH_LOG2:0]   stack_pointer,
    output logic                        stack_overflow,
    output logic                        stack_underflow,
    output logic                        busy
);

    localparam int DEPTH     = 1 << STACK_DEPTH_LOG2;
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam int IDX_W     = STACK_DEPTH_LOG2;
    localparam int SP_W      = STACK_DEPTH_LOG2 + 1;

    localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(DEPTH);
    localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       clear_idx;

    logic [DATA_WIDTH-1:0]  mem       [0:MEM_DEPTH-1];
    logic [DATA_WIDTH-1:0]  stack_mem [0:DEPTH-1];

    logic                   ready;
    logic                   push_only;
    logic                   pop_only;
    logic                   push_pop;
    logic                   sp_empty;
    logic                   sp_full;
    logic [IDX_W-1:0]       sp_idx;
    logic [IDX_W-1:0]       sp_m1;
    logic [IDX_W-1:0]       sp_m2;
    logic [DATA_WIDTH-1:0]  pop_data;

    logic                   st_we;
    logic [IDX_W-1:0]       st_waddr;
    logic [DATA_WIDTH-1:0]  st_wdata;

    assign ready     = (state == ST_READY);
    assign busy      = (state == ST_CLEAR);

    assign push_only = stack_push & ~stack_pop;
    assign pop_only  = stack_pop & ~stack_push;
    assign push_pop  = stack_push & stack_pop;

    assign sp_empty  = (stack_pointer == '0);
    assign sp_full   = (stack_pointer == SP_FULL);

    // When the stack is full the low bits wrap to 0, so sp-1 and sp-2 still
    // land on the two topmost entries.
    assign sp_idx    = stack_pointer[IDX_W-1:0];
    assign sp_m1     = sp_idx - IDX_W'(1);
    assign sp_m2     = sp_idx - IDX_W'(2);

    // Entry below the current top becomes the new top on a pop.
    assign pop_data  = stack_mem[sp_m2];

    // Stack RAM write port: clear sweep while busy, push or replace-top when ready.
    always_comb begin
        st_we    = 1'b0;
        st_waddr = clear_idx;
        st_wdata = '0;
        if (reset_n) begin
            if (state == ST_CLEAR) begin
                st_we    = 1'b1;
                st_waddr = clear_idx;
                st_wdata = '0;
            end else if (push_only && !sp_full) begin
                st_we    = 1'b1;
                st_waddr = sp_idx;
                st_wdata = value;
            end else if (push_pop && !sp_empty) begin
                st_we    = 1'b1;
                st_waddr = sp_m1;
                st_wdata = value;
            end
        end
    end

    // Stack RAM storage (contents are only meaningful once written).
    always_ff @(posedge clock) begin
        if (st_we) begin
            stack_mem[st_waddr] <= st_wdata;
        end
    end

    // Main memory write port; not touched by reset.
    always_ff @(posedge clock) begin
        if (reset_n && ready && memory_store_enable) begin
            mem[address] <= value;
        end
    end

    // Control FSM, registered read ports and stack bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state               <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clear_idx           <= '0;
            current_instruction <= '0;
            instruction_valid   <= 1'b0;
            at_memory           <= '0;
            memory_valid        <= 1'b0;
            stack_top           <= '0;
            stack_pointer       <= '0;
            stack_overflow      <= 1'b0;
            stack_underflow     <= 1'b0;
        end else begin
            instruction_valid <= 1'b0;
            memory_valid      <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clear_idx <= clear_idx + IDX_W'(1);
                    if (clear_idx == IDX_LAST) begin
                        state <= ST_READY;
                    end
                end
                ST_READY: begin
                    // Both read ports see a same-edge store to their address.
                    if (fetch_enable) begin
                        instruction_valid   <= 1'b1;
                        current_instruction <= (memory_store_enable && program_counter == address)
                                               ? value : mem[program_counter];
                    end
                    if (memory_load_enable) begin
                        memory_valid <= 1'b1;
                        at_memory    <= memory_store_enable ? value : mem[address];
                    end
                    if (push_only) begin
                        if (sp_full) begin
                            stack_overflow <= 1'b1;
                        end else begin
                            stack_pointer <= stack_pointer + SP_ONE;
                            stack_top     <= value;
                        end
                    end else if (pop_only) begin
                        if (sp_empty) begin
                            stack_underflow <= 1'b1;
                        end else if (stack_pointer == SP_ONE) begin
                            stack_pointer <= '0;
                            stack_top     <= '0;
                        end else begin
                            stack_pointer <= stack_pointer - SP_ONE;
                            stack_top     <= pop_data;
                        end
                    end else if (push_pop) begin
                        if (sp_empty) begin
                            stack_underflow <= 1'b1;
                        end else begin
                            stack_top <= value;
                        end
                    end
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_system.sv
// Directed testbench for memory_system with an 8-deep stack and a small
// main memory. Read-port responses go through expected queues checked by a
// monitor on the falling edge; stack state is checked after each operation.
module tb_memory_system;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int SL  = 3;
    localparam int SPW = SL + 1;

    logic            clock;
    logic            reset_n;
    logic [AW-1:0]   program_counter;
    logic            fetch_enable;
    logic [DW-1:0]   current_instruction;
    logic            instruction_valid;
    logic [AW-1:0]   address;
    logic [DW-1:0]   value;
    logic            memory_store_enable;
    logic            memory_load_enable;
    logic [DW-1:0]   at_memory;
    logic            memory_valid;
    logic            stack_push;
    logic            stack_pop;
    logic [DW-1:0]   stack_top;
    logic [SPW-1:0]  stack_pointer;
    logic            stack_overflow;
    logic            stack_underflow;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_instr_q[$];
    logic [DW-1:0] exp_mem_q[$];

    memory_system #(
        .DATA_WIDTH       (DW),
        .ADDR_WIDTH       (AW),
        .STACK_DEPTH_LOG2 (SL),
        .CLEAR_ON_RESET   (1'b1)
    ) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .program_counter     (program_counter),
        .fetch_enable        (fetch_enable),
        .current_instruction (current_instruction),
        .instruction_valid   (instruction_valid),
        .address             (address),
        .value               (value),
        .memory_store_enable (memory_store_enable),
        .memory_load_enable  (memory_load_enable),
        .at_memory           (at_memory),
        .memory_valid        (memory_valid),
        .stack_push          (stack_push),
        .stack_pop           (stack_pop),
        .stack_top           (stack_top),
        .stack_pointer       (stack_pointer),
        .stack_overflow      (stack_overflow),
        .stack_underflow     (stack_underflow),
        .busy                (busy)
    );

    // clock / watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // checking helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_stack(input string name, input logic [DW-1:0] top, input int sp,
                               input logic ovf, input logic unf);
        check({name, ".top"}, 32'(stack_top), 32'(top));
        check({name, ".sp"},  32'(stack_pointer), 32'(sp));
        check({name, ".ovf"}, 32'(stack_overflow), 32'(ovf));
        check({name, ".unf"}, 32'(stack_underflow), 32'(unf));
    endtask

    // monitor: pop an expectation for every valid pulse seen
    always @(negedge clock) begin
        if (instruction_valid === 1'b1) begin
            if (exp_instr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_fetch: got 0x%0h, expected no pulse", current_instruction);
            end else begin
                check("fetch", 32'(current_instruction), 32'(exp_instr_q.pop_front()));
            end
        end
        if (memory_valid === 1'b1) begin
            if (exp_mem_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_load: got 0x%0h, expected no pulse", at_memory);
            end else begin
                check("load", 32'(at_memory), 32'(exp_mem_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic clear_ops();
        fetch_enable        = 1'b0;
        memory_store_enable = 1'b0;
        memory_load_enable  = 1'b0;
        stack_push          = 1'b0;
        stack_pop           = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        clear_ops();
    endtask

    // Hold every request high while busy; returns how many busy cycles were seen.
    task automatic run_clear(output int cnt);
        cnt = 0;
        while (busy && cnt < 20) begin
            stack_push          = 1'b1;
            value               = 16'h7777;
            fetch_enable        = 1'b1;
            program_counter     = 8'h20;
            memory_load_enable  = 1'b1;
            memory_store_enable = 1'b1;
            address             = 8'h20;
            cnt++;
            cycle();
        end
    endtask

    int cnt;

    // stimulus
    initial begin
        reset_n         = 1'b0;
        program_counter = '0;
        address         = '0;
        value           = '0;
        clear_ops();
        repeat (2) cycle();

        // reset state
        check_stack("reset", 16'h0, 0, 1'b0, 1'b0);
        check("reset.busy", 32'(busy), 32'd1);
        check("reset.ivalid", 32'(instruction_valid), 32'd0);
        check("reset.mvalid", 32'(memory_valid), 32'd0);
        check("reset.instr", 32'(current_instruction), 32'd0);
        check("reset.at_mem", 32'(at_memory), 32'd0);

        // clear sweep: 8 busy cycles, requests ignored
        reset_n = 1'b1;
        run_clear(cnt);
        check("clear.busy_cycles", 32'(cnt), 32'd8);
        check("clear.busy_done", 32'(busy), 32'd0);
        check_stack("clear", 16'h0, 0, 1'b0, 1'b0);

        // store then load, then hold
        memory_store_enable = 1'b1; address = 8'h10; value = 16'hBEEF;
        cycle();
        memory_load_enable = 1'b1; address = 8'h10;
        exp_mem_q.push_back(16'hBEEF);
        cycle();
        cycle();
        check("load.hold", 32'(at_memory), 32'hBEEF);
        check("load.pulse_end", 32'(memory_valid), 32'd0);

        // write-first on both read ports
        memory_store_enable = 1'b1; memory_load_enable = 1'b1; address = 8'h10; value = 16'h1234;
        fetch_enable = 1'b1; program_counter = 8'h10;
        exp_instr_q.push_back(16'h1234);
        exp_mem_q.push_back(16'h1234);
        cycle();
        fetch_enable = 1'b1; program_counter = 8'h10;
        exp_instr_q.push_back(16'h1234);
        cycle();
        cycle();
        check("fetch.hold", 32'(current_instruction), 32'h1234);
        check("fetch.pulse_end", 32'(instruction_valid), 32'd0);

        memory_store_enable = 1'b1; address = 8'h20; value = 16'h1111;
        cycle();
        memory_store_enable = 1'b1; address = 8'h30; value = 16'h2222;
        cycle();

        // fetch, load and push on one edge
        fetch_enable = 1'b1; program_counter = 8'h30;
        memory_load_enable = 1'b1; address = 8'h20;
        stack_push = 1'b1; value = 16'h00C3;
        exp_instr_q.push_back(16'h2222);
        exp_mem_q.push_back(16'h1111);
        cycle();
        check_stack("concurrent", 16'h00C3, 1, 1'b0, 1'b0);
        stack_pop = 1'b1;
        cycle();
        check_stack("pop_last", 16'h0, 0, 1'b0, 1'b0);

        // push 1,2,3 / pop / replace top
        for (int i = 1; i <= 3; i++) begin
            stack_push = 1'b1; value = DW'(i);
            cycle();
            check_stack($sformatf("push%0d", i), DW'(i), i, 1'b0, 1'b0);
        end
        stack_pop = 1'b1;
        cycle();
        check_stack("pop3", 16'h0002, 2, 1'b0, 1'b0);
        stack_push = 1'b1; stack_pop = 1'b1; value = 16'h00AA;
        cycle();
        check_stack("replace", 16'h00AA, 2, 1'b0, 1'b0);
        stack_pop = 1'b1;
        cycle();
        check_stack("pop_after_replace", 16'h0001, 1, 1'b0, 1'b0);
        stack_pop = 1'b1;
        cycle();
        check_stack("pop_to_empty", 16'h0, 0, 1'b0, 1'b0);

        // overflow: 9 pushes of 0x11..0x19
        for (int i = 1; i <= 9; i++) begin
            stack_push = 1'b1; value = DW'(16'h10 + i);
            cycle();
            if (i <= 8) check_stack($sformatf("fill%0d", i), DW'(16'h10 + i), i, 1'b0, 1'b0);
            else        check_stack("overflow", 16'h0018, 8, 1'b1, 1'b0);
        end
        // underflow: 9 pops
        for (int i = 1; i <= 9; i++) begin
            stack_pop = 1'b1;
            cycle();
            if (i < 8)       check_stack($sformatf("drain%0d", i), DW'(16'h10 + 8 - i), 8 - i, 1'b1, 1'b0);
            else if (i == 8) check_stack("drain8", 16'h0, 0, 1'b1, 1'b0);
            else             check_stack("underflow", 16'h0, 0, 1'b1, 1'b1);
        end

        // reset with a push on the same edge, restart mid-clear
        stack_push = 1'b1; value = 16'hABCD;
        cycle();
        check_stack("push_before_reset", 16'hABCD, 1, 1'b1, 1'b1);
        reset_n = 1'b0; stack_push = 1'b1; value = 16'h4444;
        cycle();
        check_stack("reset2", 16'h0, 0, 1'b0, 1'b0);
        check("reset2.busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            memory_store_enable = 1'b1; address = 8'h20; value = 16'h7777;
            cycle();
        end
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        run_clear(cnt);
        check("restart.busy_cycles", 32'(cnt), 32'd8);
        check_stack("restart", 16'h0, 0, 1'b0, 1'b0);

        // main memory survived reset and ignored stores during clear
        fetch_enable = 1'b1; program_counter = 8'h20;
        memory_load_enable = 1'b1; address = 8'h20;
        exp_instr_q.push_back(16'h1111);
        exp_mem_q.push_back(16'h1111);
        cycle();

        // push+pop on an empty stack, then pop on empty
        stack_push = 1'b1; stack_pop = 1'b1; value = 16'h0099;
        cycle();
        check_stack("pushpop_empty", 16'h0, 0, 1'b0, 1'b1);
        stack_pop = 1'b1;
        cycle();
        check_stack("pop_empty", 16'h0, 0, 1'b0, 1'b1);
        stack_push = 1'b1; value = 16'h0077;
        cycle();
        check_stack("push_after_flags", 16'h0077, 1, 1'b0, 1'b1);

        cycle();
        cycle();
        check("instr_queue_drained", 32'(exp_instr_q.size()), 32'd0);
        check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
